cp_imem_responder: RTL and testbench

//  Instruction-memory responder: the memory end of the fetch interface. Each

---
 rtl/cp_imem_responder.sv | 118 +++++++++++
 tb/tb_cp_imem_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cp_imem_responder.sv
// Instruction-memory responder: credit-gated fixed-latency word reads queued
// into an in-order response FIFO, with a separate load port for filling the array.
module cp_imem_responder #(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_addr_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_resp_addr_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic [2:0]  inflight_o
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);

  logic [31:0]       mem [MEM_WORDS];
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     ld_idx;

  logic [READ_LATENCY-1:0] vld_p;
  logic [31:0]       addr_p [READ_LATENCY];
  logic [31:0]       data_p [READ_LATENCY];

  logic [31:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [2:0]        inflight_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_idx = instr_addr_i[AW+1:2];
  assign ld_idx = load_addr_i[AW+1:2];
  assign unused_addr_bits = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                              load_addr_i[31:AW+2], load_addr_i[1:0]};

  // Credit is taken from registered state only, so a slot is always reserved in the FIFO.
  assign issue = (inflight_q < DEPTH_C);
  assign push  = vld_p[READ_LATENCY-1];
  assign pop   = instr_valid_o & instr_ready_i;

  assign instr_valid_o     = (count != '0);
  assign instr_data_o      = instr_valid_o ? fifo_data[rd_ptr] : '0;
  assign instr_resp_addr_o = instr_valid_o ? fifo_addr[rd_ptr] : '0;
  assign inflight_o        = inflight_q;

  always_ff @(posedge clk) begin
    if (load_we_i) mem[ld_idx] <= load_data_i;
  end

  // Stage 0: the array is read at the issue edge, so a same-edge load write is not seen.
  always_ff @(posedge clk) begin
    addr_p[0] <= instr_addr_i;
    data_p[0] <= mem[rd_idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      addr_p[i] <= addr_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Final stage boundary: pipeline output enters the response FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= addr_p[READ_LATENCY-1];
      fifo_data[wr_ptr] <= data_p[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      case ({issue, pop})
        2'b10:   inflight_q <= inflight_q + 3'd1;
        2'b01:   inflight_q <= inflight_q - 3'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_cp_imem_responder.sv
// Randomized bench for cp_imem_responder against a queue-based reference model
// of outstanding reads, each tagged with the cycle its word becomes visible.
module tb_cp_imem_responder;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;
  localparam int DEPTH     = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_addr_i;
  logic        instr_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic [31:0] instr_resp_addr_o;
  logic        load_we_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic [2:0]  inflight_o;

  cp_imem_responder #(
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_addr_i      (instr_addr_i),
    .instr_ready_i     (instr_ready_i),
    .instr_valid_o     (instr_valid_o),
    .instr_data_o      (instr_data_o),
    .instr_resp_addr_o (instr_resp_addr_o),
    .load_we_i         (load_we_i),
    .load_addr_i       (load_addr_i),
    .load_data_i       (load_data_i),
    .inflight_o        (inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          avail;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mmem [MEM_WORDS];
  int          edges;
  int          n_checks;
  int          n_pass;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % MEM_WORDS;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, edges);
  endtask

  // One clock: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input logic [31:0] a, input logic rdy, input logic we,
                      input logic [31:0] la, input logic [31:0] ld);
    logic exp_v;
    logic iss;
    instr_addr_i  = a;
    instr_ready_i = rdy;
    load_we_i     = we;
    load_addr_i   = la;
    load_data_i   = ld;
    exp_v = (q.size() > 0) && (q[0].avail <= edges);
    check("valid", 32'(instr_valid_o), 32'(exp_v));
    check("inflight", 32'(inflight_o), 32'(q.size()));
    if (exp_v) begin
      check("data", instr_data_o, q[0].data);
      check("resp_addr", instr_resp_addr_o, q[0].addr);
    end
    iss = (q.size() < DEPTH);
    if (exp_v && rdy) void'(q.pop_front());
    if (iss) q.push_back('{addr: a, data: mmem[widx(a)], avail: edges + 1 + LAT});
    if (we) mmem[widx(la)] = ld;
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] la;
    n_checks = 0;
    n_pass   = 0;
    edges    = 0;
    rst_n         = 1'b0;
    instr_addr_i  = '0;
    instr_ready_i = 1'b0;
    load_we_i     = 1'b0;
    load_addr_i   = '0;
    load_data_i   = '0;

    // Preload the whole array while held in reset.
    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge clk);
      load_we_i   = 1'b1;
      load_addr_i = 32'(i * 4);
      load_data_i = 32'h1000_0000 + 32'(i);
      mmem[i]     = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    load_we_i = 1'b0;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_inflight", 32'(inflight_o), 32'd0);
    check("rst_data", instr_data_o, 32'd0);
    check("rst_resp_addr", instr_resp_addr_o, 32'd0);
    rst_n = 1'b1;

    // Sequential stream, then a stall, then toggling ready.
    for (int i = 0; i < 12; i++) step(32'(i * 4), 1'b1, 1'b0, '0, '0);
    for (int i = 12; i < 18; i++) step(32'(i * 4), 1'b0, 1'b0, '0, '0);
    check("saturated_inflight", 32'(inflight_o), 32'(DEPTH));
    for (int i = 18; i < 38; i++) step(32'(i * 4), 1'(i % 2), 1'b0, '0, '0);

    // Load/read collision on word 5, then a read of it issued one cycle later.
    step(32'h14, 1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF);
    step(32'h14, 1'b1, 1'b0, '0, '0);
    // Out-of-range address wraps onto word 0.
    step(32'h0000_1000, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) step(32'(i * 4), 1'b1, 1'b0, '0, '0);

    // Queue a few words, then pulse reset mid-operation.
    for (int i = 0; i < 5; i++) step(32'(i * 4 + 64), 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(instr_valid_o), 32'd0);
    check("midrst_inflight", 32'(inflight_o), 32'd0);
    q.delete();
    @(posedge clk);
    edges++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(32'(i * 4 + 128), 1'b1, 1'b0, '0, '0);

    // Random traffic with wrapping addresses and frequent load collisions.
    for (int i = 0; i < 500; i++) begin
      a  = $urandom();
      la = ($urandom_range(0, 1) == 1) ? a : $urandom();
      step(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), la, $urandom());
    end
    for (int i = 0; i < 12; i++) step($urandom(), 1'b1, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
